alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Drives the operand/control side of the 4:1 result mux (plus/minus/mult selected by add/sub). Accepts operand and opcode tokens over a valid/ready input channel, presents a/b/add/sub to the mux, and waits a fixed settle time. It then captures the mux result f and returns it on a valid/ready result channel.
- Sits between the front-panel/command source and the mux datapath.

Parameters:
- DATA_W, 4, operand width driven on alu_a/alu_b
- RES_W, 8, width of mux result alu_f and res_data
- SETTLE_CYCLES, 2, cycles alu_* held stable before capture (legal range 1..15)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  token present
- in_ready  output  1  sequencer accepts token this cycle
- in_kind  input  2  0=load A, 1=load B, 2=load opcode, 3=go
- in_data  input  DATA_W  payload; opcode uses bits [1:0]
- alu_a  output  DATA_W  operand A to mux
- alu_b  output  DATA_W  operand B to mux
- alu_add  output  1  mux add control
- alu_sub  output  1  mux sub control
- alu_f  input  RES_W  mux result
- res_valid  output  1  result held for consumer
- res_ready  input  1  consumer takes result
- res_data  output  RES_W  captured result
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky; set on illegal opcode go

Behaviour:
- Reset (async assert, sync release): state=IDLE; alu_a=0, alu_b=0, op register=3, alu_add=1, alu_sub=1, res_data=0, res_valid=0, err=0, in_ready=1, busy=0.
- Opcode to controls, registered: 0 ADD -> add=0,sub=1; 1 SUB -> add=1,sub=0; 2 MUL -> add=0,sub=0; 3 illegal -> add=1,sub=1.
- A token transfers on a cycle where in_valid&in_ready are both high. in_ready=1 only in IDLE.
- IDLE:
  - kind 0/1: load alu_a/alu_b next edge.
  - kind 2: load op and update alu_add/alu_sub next edge.
  - kind 3 with op<=2: go to DRIVE and load settle counter with SETTLE_CYCLES-1.
  - kind 3 with op=3: set err, stay in IDLE, no result produced.
- Loaded A/B/op persist across operations; a repeated go reuses them.
- DRIVE: alu_a/alu_b/alu_add/alu_sub frozen. Counter decrements each cycle. At 0, go to CAPTURE.
- CAPTURE: one cycle. res_data<=alu_f, res_valid<=1, go to HOLD.
- HOLD: res_data and res_valid stable until res_ready=1. Next edge clears res_valid and returns to IDLE. If res_ready is already high on HOLD entry, the state lasts 1 cycle.
- Latency: go accepted at edge N -> res_valid high from edge N+SETTLE_CYCLES+1.
- Result width: res_data equals alu_f verbatim. No sign extension or masking is done here.
- err is sticky and cleared only by a successful go (op<=2) or by reset.
- A go token while busy is not accepted because in_ready=0. The source must hold the token.
- Reset mid-operation: immediate return to reset values. Any pending result is discarded and res_valid drops asynchronously.
- Tokens with in_valid=0 are ignored regardless of kind/data.

Optional Feature:
- RESULT_CHECK_EN:
  - When defined, add output port chk_mismatch (1 bit, reset 0).
  - In CAPTURE, compute the expected value from the frozen operands, zero-extended to RES_W: A+B, A-B (two's complement, truncated to RES_W), or A*B.
  - chk_mismatch is set for the HOLD duration if expected != alu_f, and cleared on leaving HOLD.
- When not defined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release -> in_ready=1, busy=0, alu_add=1, alu_sub=1, res_valid=0, err=0.
- Load A=5, B=3, op=0, go; bench mux returns a+b -> alu_add=0/alu_sub=1, res_valid at go+3 cycles (SETTLE_CYCLES=2), res_data=8'h08.
- Op=1 then op=2 on the same operands, with res_ready held high -> results 8'h02 then 8'h0F. Each HOLD lasts 1 cycle. in_ready=0 throughout DRIVE/CAPTURE/HOLD.
- Op=3, go -> err=1, no res_valid. Then op=2, go -> err clears, res_data=8'h0F.
- res_ready held low 10 cycles after a result -> res_data/res_valid stable, go token stalled with in_ready=0. res_ready pulse -> IDLE next edge.
- rst_n low during DRIVE -> outputs immediately at reset values. With RESULT_CHECK_EN, a bench mux that returns 8'h07 for 5+3 -> chk_mismatch=1 during HOLD.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: collects operand/opcode tokens, drives the 4:1 result mux
// controls, waits a fixed settle time, then captures and hands back the mux result.
// Optional build macro RESULT_CHECK_EN adds the chk_mismatch self-check output.
module alu_op_sequencer #(
  parameter int DATA_W        = 4,
  parameter int RES_W         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_add,
  output logic              alu_sub,
  input  logic [RES_W-1:0]  alu_f,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              busy,
  output logic              err
`ifdef RESULT_CHECK_EN
  ,
  output logic              chk_mismatch
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic              add_q, add_d, sub_q, sub_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [RES_W-1:0]  resData_q, resData_d;
  logic              resValid_q, resValid_d;
  logic              err_q, err_d;

  // Mux control pair {add, sub} for each opcode; opcode 3 parks the mux on its unused input.
  function automatic logic [1:0] opCtl(input logic [1:0] op);
    case (op)
      2'd0:    opCtl = 2'b01;
      2'd1:    opCtl = 2'b10;
      2'd2:    opCtl = 2'b00;
      default: opCtl = 2'b11;
    endcase
  endfunction

`ifdef RESULT_CHECK_EN
  logic             chk_q, chk_d;
  logic [RES_W-1:0] aExt, bExt, expected;

  // Reference result from the frozen operands, zero-extended and truncated to RES_W.
  always_comb begin
    aExt = RES_W'(a_q);
    bExt = RES_W'(b_q);
    case (op_q)
      2'd0:    expected = aExt + bExt;
      2'd1:    expected = aExt - bExt;
      2'd2:    expected = aExt * bExt;
      default: expected = '0;
    endcase
  end
`endif

  // Next-state logic: token handling in IDLE, settle countdown, capture and hand-off.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    add_d      = add_q;
    sub_d      = sub_q;
    cnt_d      = cnt_q;
    resData_d  = resData_q;
    resValid_d = resValid_q;
    err_d      = err_q;
`ifdef RESULT_CHECK_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (in_kind)
            2'd0: a_d = in_data;
            2'd1: b_d = in_data;
            2'd2: begin
              op_d           = in_data[1:0];
              {add_d, sub_d} = opCtl(in_data[1:0]);
            end
            default: begin
              if (op_q == 2'd3) begin
                err_d = 1'b1;
              end else begin
                err_d   = 1'b0;
                cnt_d   = SETTLE_INIT;
                state_d = DRIVE;
              end
            end
          endcase
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        resData_d  = alu_f;
        resValid_d = 1'b1;
        state_d    = HOLD;
`ifdef RESULT_CHECK_EN
        chk_d      = (expected != alu_f);
`endif
      end
      HOLD: begin
        if (res_ready) begin
          resValid_d = 1'b0;
          state_d    = IDLE;
`ifdef RESULT_CHECK_EN
          chk_d      = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset parks the mux controls on the illegal opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 2'd3;
      add_q      <= 1'b1;
      sub_q      <= 1'b1;
      cnt_q      <= '0;
      resData_q  <= '0;
      resValid_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef RESULT_CHECK_EN
      chk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      add_q      <= add_d;
      sub_q      <= sub_d;
      cnt_q      <= cnt_d;
      resData_q  <= resData_d;
      resValid_q <= resValid_d;
      err_q      <= err_d;
`ifdef RESULT_CHECK_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_add   = add_q;
  assign alu_sub   = sub_q;
  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign err       = err_q;
`ifdef RESULT_CHECK_EN
  assign chk_mismatch = chk_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives token sequences into alu_op_sequencer with a bench-side
// mux, and compares against an arithmetic model of the loaded operands and opcode.
module tb_alu_op_sequencer;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_kind = 2'd0;
  logic [3:0] in_data = 4'd0;
  logic       res_ready = 1'b0;
  logic       muxFault = 1'b0;
  logic [7:0] alu_f;
  logic       in_ready, alu_add, alu_sub, res_valid, busy, err;
  logic [3:0] alu_a, alu_b;
  logic [7:0] res_data;
`ifdef RESULT_CHECK_EN
  logic       chk_mismatch;
`endif

  int nChecks = 0;
  int nFails  = 0;

  int   mA = 0, mB = 0, mOp = 3;
  logic mErr = 1'b0;

  alu_op_sequencer #(.DATA_W(4), .RES_W(8), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_data(in_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_f(alu_f), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy), .err(err)
`ifdef RESULT_CHECK_EN
    , .chk_mismatch(chk_mismatch)
`endif
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Bench-side 4:1 result mux; muxFault forces a wrong answer.
  always_comb begin
    case ({alu_add, alu_sub})
      2'b01:   alu_f = {4'b0, alu_a} + {4'b0, alu_b};
      2'b10:   alu_f = {4'b0, alu_a} - {4'b0, alu_b};
      2'b00:   alu_f = {4'b0, alu_a} * {4'b0, alu_b};
      default: alu_f = 8'hFF;
    endcase
    if (muxFault) alu_f = 8'h07;
  end

  // Watchdog against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] modelResult(input int a, input int b, input int op);
    case (op)
      0:       modelResult = 8'((a + b) & 255);
      1:       modelResult = 8'((a - b) & 255);
      default: modelResult = 8'((a * b) & 255);
    endcase
  endfunction

  function automatic logic [1:0] modelCtl(input int op);
    case (op)
      0:       modelCtl = 2'b01;
      1:       modelCtl = 2'b10;
      2:       modelCtl = 2'b00;
      default: modelCtl = 2'b11;
    endcase
  endfunction

  task automatic send(input logic [1:0] kind, input logic [3:0] data);
    @(negedge clk);
    in_valid = 1'b1;
    in_kind  = kind;
    in_data  = data;
    @(negedge clk);
    in_valid = 1'b0;
    in_kind  = 2'($urandom);
    in_data  = 4'($urandom);
    case (kind)
      2'd0: mA = int'(data);
      2'd1: mB = int'(data);
      2'd2: mOp = int'(data[1:0]);
      default: mErr = (mOp == 3);
    endcase
  endtask

  task automatic waitValid(output int cycles, output bit leak);
    logic [9:0] snap;
    snap = {alu_a, alu_b, alu_add, alu_sub};
    cycles = 0;
    leak = 1'b0;
    while (res_valid !== 1'b1 && cycles < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || {alu_a, alu_b, alu_add, alu_sub} !== snap) leak = 1'b1;
      @(negedge clk);
      cycles++;
    end
    if (in_ready !== 1'b0 || busy !== 1'b1) leak = 1'b1;
  endtask

  task automatic modelReset();
    mA = 0; mB = 0; mOp = 3; mErr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    @(negedge clk);
    nChecks++; if ({in_ready, busy} !== 2'b10) begin nFails++; $display("[TB] FAIL reset_ready_busy: got %b expected 10", {in_ready, busy}); end
    nChecks++; if ({alu_add, alu_sub} !== 2'b11) begin nFails++; $display("[TB] FAIL reset_ctl: got %b expected 11", {alu_add, alu_sub}); end
    nChecks++; if ({res_valid, err} !== 2'b00) begin nFails++; $display("[TB] FAIL reset_valid_err: got %b expected 00", {res_valid, err}); end
    nChecks++; if ({alu_a, alu_b, res_data} !== 16'h0) begin nFails++; $display("[TB] FAIL reset_data: got %h expected 0000", {alu_a, alu_b, res_data}); end
  endtask

  task automatic test_add();
    int cyc; bit leak;
    res_ready = 1'b0;
    send(2'd0, 4'd5); send(2'd1, 4'd3); send(2'd2, 4'd0);
    nChecks++; if ({alu_add, alu_sub} !== 2'b01) begin nFails++; $display("[TB] FAIL add_ctl: got %b expected 01", {alu_add, alu_sub}); end
    nChecks++; if ({alu_a, alu_b} !== 8'h53) begin nFails++; $display("[TB] FAIL add_operands: got %h expected 53", {alu_a, alu_b}); end
    send(2'd3, 4'd0);
    waitValid(cyc, leak);
    nChecks++; if (cyc != SETTLE + 1) begin nFails++; $display("[TB] FAIL add_latency: got %0d expected %0d", cyc, SETTLE + 1); end
    nChecks++; if (res_data !== 8'h08) begin nFails++; $display("[TB] FAIL add_result: got %h expected 08", res_data); end
    nChecks++; if (leak) begin nFails++; $display("[TB] FAIL add_busy_window: got leak=1 expected 0"); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    nChecks++; if ({res_valid, in_ready} !== 2'b01) begin nFails++; $display("[TB] FAIL add_release: got %b expected 01", {res_valid, in_ready}); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit leak;
    logic [7:0] exp [2];
    exp[0] = 8'h02; exp[1] = 8'h0F;
    res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(2'd2, 4'(i + 1));
      send(2'd3, 4'd0);
      waitValid(cyc, leak);
      nChecks++; if (cyc != SETTLE + 1) begin nFails++; $display("[TB] FAIL b2b_latency_%0d: got %0d expected %0d", i, cyc, SETTLE + 1); end
      nChecks++; if (res_data !== exp[i]) begin nFails++; $display("[TB] FAIL b2b_result_%0d: got %h expected %h", i, res_data, exp[i]); end
      nChecks++; if (leak) begin nFails++; $display("[TB] FAIL b2b_busy_window_%0d: got leak=1 expected 0", i); end
      @(negedge clk);
      nChecks++; if ({res_valid, in_ready} !== 2'b01) begin nFails++; $display("[TB] FAIL b2b_hold_one_cycle_%0d: got %b expected 01", i, {res_valid, in_ready}); end
    end
    res_ready = 1'b0;
  endtask

  task automatic test_illegal();
    int cyc; bit leak; bit sawValid;
    send(2'd2, 4'd3);
    nChecks++; if ({alu_add, alu_sub} !== 2'b11) begin nFails++; $display("[TB] FAIL illegal_ctl: got %b expected 11", {alu_add, alu_sub}); end
    send(2'd3, 4'd0);
    nChecks++; if ({err, in_ready, busy} !== 3'b110) begin nFails++; $display("[TB] FAIL illegal_err: got %b expected 110", {err, in_ready, busy}); end
    sawValid = 1'b0;
    repeat (5) begin @(negedge clk); if (res_valid !== 1'b0) sawValid = 1'b1; end
    nChecks++; if (sawValid) begin nFails++; $display("[TB] FAIL illegal_no_result: got res_valid=1 expected 0"); end
    nChecks++; if (err !== 1'b1) begin nFails++; $display("[TB] FAIL illegal_err_sticky: got %b expected 1", err); end
    send(2'd2, 4'd2);
    send(2'd3, 4'd0);
    nChecks++; if (err !== 1'b0) begin nFails++; $display("[TB] FAIL illegal_err_clear: got %b expected 0", err); end
    waitValid(cyc, leak);
    nChecks++; if (res_data !== 8'h0F) begin nFails++; $display("[TB] FAIL illegal_recover_result: got %h expected 0F", res_data); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    int cyc; bit leak; bit unstable; bit accepted;
    res_ready = 1'b0;
    send(2'd3, 4'd0);
    waitValid(cyc, leak);
    in_valid = 1'b1; in_kind = 2'd3; in_data = 4'($urandom);
    unstable = 1'b0; accepted = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 8'h0F) unstable = 1'b1;
      if (in_ready !== 1'b0) accepted = 1'b1;
    end
    nChecks++; if (unstable) begin nFails++; $display("[TB] FAIL stall_result_stable: got %b/%h expected 1/0f", res_valid, res_data); end
    nChecks++; if (accepted) begin nFails++; $display("[TB] FAIL stall_in_ready: got in_ready=1 expected 0"); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    nChecks++; if ({res_valid, in_ready} !== 2'b01) begin nFails++; $display("[TB] FAIL stall_release: got %b expected 01", {res_valid, in_ready}); end
    @(negedge clk);
    in_valid = 1'b0;
    mErr = 1'b0;
    waitValid(cyc, leak);
    nChecks++; if (cyc != SETTLE + 1 || res_data !== 8'h0F) begin nFails++; $display("[TB] FAIL stall_held_go: got %0d/%h expected %0d/0f", cyc, res_data, SETTLE + 1); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    int cyc; bit leak; int nLoads; int holdCyc; bit dropped;
    logic [7:0] exp;
    for (int it = 0; it < 25; it++) begin
      nLoads = int'($urandom_range(1, 4));
      for (int k = 0; k < nLoads; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          in_valid = 1'b0; in_kind = 2'($urandom); in_data = 4'($urandom);
        end
        send(2'($urandom_range(0, 2)), 4'($urandom));
      end
      nChecks++; if ({alu_a, alu_b} !== {4'(mA), 4'(mB)}) begin nFails++; $display("[TB] FAIL rnd_operands_%0d: got %h expected %h", it, {alu_a, alu_b}, {4'(mA), 4'(mB)}); end
      nChecks++; if ({alu_add, alu_sub} !== modelCtl(mOp)) begin nFails++; $display("[TB] FAIL rnd_ctl_%0d: got %b expected %b", it, {alu_add, alu_sub}, modelCtl(mOp)); end
      nChecks++; if (err !== mErr) begin nFails++; $display("[TB] FAIL rnd_err_pre_%0d: got %b expected %b", it, err, mErr); end
      holdCyc = int'($urandom_range(0, 3));
      res_ready = (holdCyc == 0);
      send(2'd3, 4'($urandom));
      nChecks++; if (err !== mErr) begin nFails++; $display("[TB] FAIL rnd_err_go_%0d: got %b expected %b", it, err, mErr); end
      if (mOp == 3) begin
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL rnd_illegal_idle_%0d: got busy=%b expected 0", it, busy); end
        res_ready = 1'b0;
      end else begin
        exp = modelResult(mA, mB, mOp);
        waitValid(cyc, leak);
        nChecks++; if (cyc != SETTLE + 1) begin nFails++; $display("[TB] FAIL rnd_latency_%0d: got %0d expected %0d", it, cyc, SETTLE + 1); end
        nChecks++; if (res_data !== exp) begin nFails++; $display("[TB] FAIL rnd_result_%0d: got %h expected %h", it, res_data, exp); end
        nChecks++; if (leak) begin nFails++; $display("[TB] FAIL rnd_busy_window_%0d: got leak=1 expected 0", it); end
`ifdef RESULT_CHECK_EN
        nChecks++; if (chk_mismatch !== 1'b0) begin nFails++; $display("[TB] FAIL rnd_chk_%0d: got %b expected 0", it, chk_mismatch); end
`endif
        dropped = 1'b0;
        repeat (holdCyc) begin
          @(negedge clk);
          if (res_valid !== 1'b1 || res_data !== exp) dropped = 1'b1;
        end
        nChecks++; if (dropped) begin nFails++; $display("[TB] FAIL rnd_hold_%0d: got %b/%h expected 1/%h", it, res_valid, res_data, exp); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        nChecks++; if ({res_valid, in_ready} !== 2'b01) begin nFails++; $display("[TB] FAIL rnd_release_%0d: got %b expected 01", it, {res_valid, in_ready}); end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc; bit leak;
    res_ready = 1'b0;
    send(2'd0, 4'd9); send(2'd1, 4'd6); send(2'd2, 4'd2);
    send(2'd3, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    nChecks++; if ({busy, in_ready, res_valid, err} !== 4'b0100) begin nFails++; $display("[TB] FAIL rst_drive_flags: got %b expected 0100", {busy, in_ready, res_valid, err}); end
    nChecks++; if ({alu_a, alu_b, alu_add, alu_sub} !== 10'b0000_0000_11) begin nFails++; $display("[TB] FAIL rst_drive_alu: got %b expected 0000000011", {alu_a, alu_b, alu_add, alu_sub}); end
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd0, 4'd7); send(2'd1, 4'd2); send(2'd2, 4'd0);
    send(2'd3, 4'd0);
    waitValid(cyc, leak);
    nChecks++; if (res_data !== 8'h09) begin nFails++; $display("[TB] FAIL rst_pre_hold_result: got %h expected 09", res_data); end
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    nChecks++; if ({res_valid, res_data, busy} !== 10'b0_00000000_0) begin nFails++; $display("[TB] FAIL rst_hold_drop: got %b/%h/%b expected 0/00/0", res_valid, res_data, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef RESULT_CHECK_EN
  task automatic test_check_feature();
    int cyc; bit leak;
    res_ready = 1'b0;
    send(2'd0, 4'd5); send(2'd1, 4'd3); send(2'd2, 4'd0);
    muxFault = 1'b1;
    send(2'd3, 4'd0);
    waitValid(cyc, leak);
    nChecks++; if (res_data !== 8'h07) begin nFails++; $display("[TB] FAIL chk_result: got %h expected 07", res_data); end
    nChecks++; if (chk_mismatch !== 1'b1) begin nFails++; $display("[TB] FAIL chk_set: got %b expected 1", chk_mismatch); end
    @(negedge clk);
    nChecks++; if (chk_mismatch !== 1'b1) begin nFails++; $display("[TB] FAIL chk_hold: got %b expected 1", chk_mismatch); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    muxFault = 1'b0;
    nChecks++; if (chk_mismatch !== 1'b0) begin nFails++; $display("[TB] FAIL chk_clear: got %b expected 0", chk_mismatch); end
  endtask
`endif

  // Scenario sequence.
  initial begin
    $display("[TB] starting alu_op_sequencer bench");
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_hold_stall();
    test_random();
    test_reset_mid_op();
`ifdef RESULT_CHECK_EN
    test_check_feature();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
